// File: rtl/credit_bp_tx_if.sv
// Credit-based NoC link between a transmitter and a switch/pipe receiver.
// Carries one packet per cycle, a one-hot VC target and per-VC credit grants.
interface noc_if #(
    parameter int A_W  = 4,
    parameter int D_W  = 8,
    parameter int VC_W = 2
);
    typedef struct packed {
        logic [A_W-1:0] addr;
    } noc_routeinfo_t;

    typedef struct packed {
        logic [D_W-1:0] data;
        logic           last;
    } noc_payload_t;

    typedef struct packed {
        noc_routeinfo_t routeinfo;
        noc_payload_t   payload;
    } noc_packet_t;

    noc_packet_t     credit_packet;
    logic [VC_W-1:0] credit_vc_target;
    logic [VC_W-1:0] credit_vc_credit_gnt;

    modport transmitter (
        output credit_packet,
        output credit_vc_target,
        input  credit_vc_credit_gnt
    );

    modport receiver (
        input  credit_packet,
        input  credit_vc_target,
        output credit_vc_credit_gnt
    );
endinterface

// File: rtl/credit_bp_tx.sv
// Client injection stage: turns a valid/backpressure flit stream into the
// credit-based noc_if transmitter side, one credit counter per VC.
module credit_bp_tx #(
    parameter int DEFAULT_N             = 8,
    parameter int DEFAULT_A_W           = 4,
    parameter int DEFAULT_D_W           = 8,
    parameter int DEFAULT_VC_W          = 2,
    parameter int DEFAULT_VC_FIFO_DEPTH = 4,
    parameter int N                     = DEFAULT_N,
    parameter int A_W                   = DEFAULT_A_W,
    parameter int D_W                   = DEFAULT_D_W,
    parameter int VC_W                  = DEFAULT_VC_W,
    parameter int VC_FIFO_DEPTH         = DEFAULT_VC_FIFO_DEPTH,
    localparam int IW                   = (VC_W > 1) ? $clog2(VC_W) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_v,
    input  logic [A_W+D_W:0] i_d,
    input  logic [IW-1:0]    i_vc,
    output logic             o_b,
    noc_if.transmitter       to_rx,
    output logic             o_err
);
    localparam int CW = $clog2(VC_FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] CRED_MAX = CW'(VC_FIFO_DEPTH - 1);

    logic [CW-1:0]    cred_r     [VC_W];
    logic [CW-1:0]    cred_nxt_s [VC_W];
    logic [VC_W-1:0]  dec_s;
    logic [VC_W-1:0]  tgt_r;
    logic [A_W+D_W:0] pkt_r;
    logic             vc_ok_s;
    logic             fire_s;
    logic             err_nxt_s;
    logic             err_r;

    // Backpressure from registered credits and the requested VC only.
    always_comb begin
        vc_ok_s = (int'(i_vc) < VC_W);
        if (vc_ok_s) begin
            o_b = (cred_r[i_vc] == {CW{1'b0}});
        end else begin
            o_b = 1'b1;
        end
        fire_s = i_v & ~o_b;
        if (fire_s) begin
            dec_s = VC_W'(1'b1) << i_vc;
        end else begin
            dec_s = {VC_W{1'b0}};
        end
    end

    // Next credit per VC and error accumulation; a grant at full credit is an overflow.
    always_comb begin
        err_nxt_s = err_r | (i_v & ~vc_ok_s);
        for (int v = 0; v < VC_W; v++) begin
            cred_nxt_s[v] = cred_r[v];
            if (to_rx.credit_vc_credit_gnt[v] && (cred_r[v] == CRED_MAX)) begin
                err_nxt_s = 1'b1;
            end else begin
                err_nxt_s = err_nxt_s;
            end
            case ({to_rx.credit_vc_credit_gnt[v], dec_s[v]})
                2'b10: begin
                    if (cred_r[v] != CRED_MAX) begin
                        cred_nxt_s[v] = cred_r[v] + CW'(1'b1);
                    end else begin
                        cred_nxt_s[v] = cred_r[v];
                    end
                end
                2'b01:   cred_nxt_s[v] = cred_r[v] - CW'(1'b1);
                default: cred_nxt_s[v] = cred_r[v];
            endcase
        end
    end

    // State registers: credits, sticky error, registered output flit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int v = 0; v < VC_W; v++) begin
                cred_r[v] <= CRED_MAX;
            end
            err_r <= 1'b0;
            tgt_r <= {VC_W{1'b0}};
            pkt_r <= {(A_W+D_W+1){1'b0}};
        end else begin
            for (int v = 0; v < VC_W; v++) begin
                cred_r[v] <= cred_nxt_s[v];
            end
            err_r <= err_nxt_s;
            tgt_r <= dec_s;
            if (fire_s) begin
                pkt_r <= i_d;
            end else begin
                pkt_r <= pkt_r;
            end
        end
    end

    assign to_rx.credit_vc_target = tgt_r;
    assign to_rx.credit_packet    = {pkt_r[A_W+D_W-1:D_W], pkt_r[D_W-1:0], pkt_r[A_W+D_W]};
    assign o_err                  = err_r;

    credit_bp_tx_chk #(.N(N), .A_W(A_W), .IW(IW)) u_chk (
        .clk  (clk),
        .rst  (rst),
        .fire (fire_s),
        .vc   (i_vc),
        .addr (i_d[A_W+D_W-1:D_W]),
        .last (i_d[A_W+D_W])
    );
endmodule

// Protocol checks on accepted flits: one VC per packet, address inside client range.
module credit_bp_tx_chk #(
    parameter int N   = 8,
    parameter int A_W = 4,
    parameter int IW  = 1
) (
    input logic           clk,
    input logic           rst,
    input logic           fire,
    input logic [IW-1:0]  vc,
    input logic [A_W-1:0] addr,
    input logic           last
);
    logic          in_pkt_r;
    logic [IW-1:0] pkt_vc_r;

    // Remember the VC of the packet in progress until its last flit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_pkt_r <= 1'b0;
            pkt_vc_r <= {IW{1'b0}};
        end else if (fire) begin
            in_pkt_r <= ~last;
            pkt_vc_r <= vc;
        end else begin
            in_pkt_r <= in_pkt_r;
            pkt_vc_r <= pkt_vc_r;
        end
    end

    a_vc_stable: assert property (@(posedge clk) disable iff (!rst)
        (fire && in_pkt_r) |-> (vc == pkt_vc_r));

    a_addr_range: assert property (@(posedge clk) disable iff (!rst)
        fire |-> (int'(addr) < N));
endmodule

// File: tb/tb_credit_bp_tx.sv
// Randomized scoreboard bench for credit_bp_tx against a credit-accounting model.
module tb_credit_bp_tx;
    localparam int MAXC = 3;

    typedef struct {
        logic [1:0] tgt;
        logic [3:0] addr;
        logic [7:0] data;
        logic       last;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       i_v = 1'b0;
    logic [12:0] i_d = 13'd0;
    logic       i_vc = 1'b0;
    logic       o_b, o_err;

    logic       i_v3 = 1'b0;
    logic [12:0] i_d3 = 13'd0;
    logic [1:0] i_vc3 = 2'd0;
    logic       o_b3, o_err3;

    int   n_chk = 0;
    int   n_pass = 0;
    exp_t exp_q[$];
    int   m_cred[2];
    logic m_err;

    noc_if #(.A_W(4), .D_W(8), .VC_W(2)) nif ();
    noc_if #(.A_W(4), .D_W(8), .VC_W(3)) nif3 ();

    credit_bp_tx #(.N(8), .A_W(4), .D_W(8), .VC_W(2), .VC_FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst_n), .i_v(i_v), .i_d(i_d), .i_vc(i_vc),
        .o_b(o_b), .to_rx(nif), .o_err(o_err)
    );

    credit_bp_tx #(.N(8), .A_W(4), .D_W(8), .VC_W(3), .VC_FIFO_DEPTH(4)) dut3 (
        .clk(clk), .rst(rst_n), .i_v(i_v3), .i_d(i_d3), .i_vc(i_vc3),
        .o_b(o_b3), .to_rx(nif3), .o_err(o_err3)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act === expv) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    // Monitor: every non-zero target must match the oldest expected flit.
    always @(negedge clk) begin
        if (rst_n) begin
            if (nif.credit_vc_target != 2'b00) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_flit", 32'(nif.credit_vc_target), 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("flit", {17'd0, nif.credit_vc_target, nif.credit_packet.routeinfo.addr,
                                 nif.credit_packet.payload.data, nif.credit_packet.payload.last},
                                {17'd0, e.tgt, e.addr, e.data, e.last});
                end
            end else if (exp_q.size() != 0) begin
                chk("missing_flit", 32'd0, 32'(exp_q[0].tgt));
                void'(exp_q.pop_front());
            end
        end
    end

    task automatic model_reset();
        m_cred[0] = MAXC;
        m_cred[1] = MAXC;
        m_err     = 1'b0;
        exp_q.delete();
    endtask

    // One cycle: drive at posedge+1, check o_b/o_err at negedge, update model at posedge.
    task automatic step(input logic v, input logic vc, input logic [3:0] a,
                        input logic [7:0] d, input logic l, input logic [1:0] g);
        logic mob;
        int   pre[2];
        exp_t e;
        i_v = v; i_vc = vc; i_d = {l, a, d}; nif.credit_vc_credit_gnt = g;
        @(negedge clk);
        mob = (m_cred[vc] == 0);
        chk("o_b", 32'(o_b), 32'(mob));
        chk("o_err", 32'(o_err), 32'(m_err));
        @(posedge clk);
        pre[0] = m_cred[0];
        pre[1] = m_cred[1];
        if (v && !mob) begin
            e.tgt = vc ? 2'b10 : 2'b01; e.addr = a; e.data = d; e.last = l;
            exp_q.push_back(e);
        end
        for (int k = 0; k < 2; k++) begin
            if (g[k] && pre[k] == MAXC) m_err = 1'b1;
            m_cred[k] = pre[k] - ((v && !mob && int'(vc) == k) ? 1 : 0) + (g[k] ? 1 : 0);
            if (m_cred[k] > MAXC) m_cred[k] = MAXC;
        end
        #1;
    endtask

    initial begin
        logic       open;
        logic       cur_vc;
        logic       v, l;
        logic [1:0] g;
        model_reset();
        nif.credit_vc_credit_gnt  = 2'b00;
        nif3.credit_vc_credit_gnt = 3'b000;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        @(negedge clk);
        chk("rst_target", 32'(nif.credit_vc_target), 32'd0);
        chk("rst_o_b", 32'(o_b), 32'd0);
        chk("rst_o_err", 32'(o_err), 32'd0);
        chk("rst_cred0", 32'(dut.cred_r[0]), 32'(MAXC));
        chk("rst_cred1", 32'(dut.cred_r[1]), 32'(MAXC));
        @(posedge clk); #1;

        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 4'(i + 1), 8'(8'h10 + i), 1'b1, 2'b00);
        step(1'b1, 1'b0, 4'd4, 8'h13, 1'b1, 2'b00);
        step(1'b1, 1'b0, 4'd4, 8'h13, 1'b1, 2'b00);
        step(1'b1, 1'b0, 4'd4, 8'h13, 1'b1, 2'b01);
        step(1'b1, 1'b0, 4'd4, 8'h13, 1'b1, 2'b00);
        step(1'b1, 1'b1, 4'd6, 8'h21, 1'b1, 2'b00);
        step(1'b1, 1'b1, 4'd7, 8'h22, 1'b1, 2'b00);
        chk("vc0_exhausted", 32'(dut.cred_r[0]), 32'd0);
        step(1'b1, 1'b1, 4'd3, 8'h23, 1'b1, 2'b10);
        chk("same_vc_dec_gnt", 32'(dut.cred_r[1]), 32'd1);
        step(1'b0, 1'b1, 4'd0, 8'h00, 1'b0, 2'b10);
        step(1'b1, 1'b1, 4'd5, 8'hA5, 1'b0, 2'b00);
        step(1'b1, 1'b1, 4'd5, 8'h5A, 1'b1, 2'b00);
        step(1'b0, 1'b1, 4'd0, 8'h00, 1'b0, 2'b00);

        open = 1'b0;
        cur_vc = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (!open) cur_vc = 1'($urandom_range(0, 1));
            v = ($urandom_range(0, 3) != 0);
            l = ($urandom_range(0, 2) == 0);
            for (int k = 0; k < 2; k++) g[k] = (m_cred[k] < MAXC) && ($urandom_range(0, 2) == 0);
            if (v && m_cred[cur_vc] != 0) open = ~l;
            step(v, cur_vc, 4'($urandom_range(0, 7)), 8'($urandom_range(0, 255)), l, g);
        end
        for (int i = 0; i < 8 && open; i++) begin
            if (m_cred[cur_vc] != 0) open = 1'b0;
            step(1'b1, cur_vc, 4'd1, 8'hEE, 1'b1, 2'b00);
        end

        for (int i = 0; i < 8; i++) begin
            g[0] = (m_cred[0] < MAXC);
            g[1] = (m_cred[1] < MAXC);
            step(1'b0, 1'b0, 4'd0, 8'h00, 1'b0, g);
        end
        step(1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 2'b01);
        chk("ovf_cred0_max", 32'(dut.cred_r[0]), 32'(MAXC));
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 2'b00);

        step(1'b1, 1'b0, 4'd2, 8'h77, 1'b1, 2'b00);
        step(1'b1, 1'b1, 4'd3, 8'h78, 1'b0, 2'b00);
        rst_n = 1'b0;
        #1;
        chk("async_target_drop", 32'(nif.credit_vc_target), 32'd0);
        model_reset();
        i_v = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst2_cred0", 32'(dut.cred_r[0]), 32'(MAXC));
        chk("rst2_cred1", 32'(dut.cred_r[1]), 32'(MAXC));
        chk("rst2_o_err", 32'(o_err), 32'd0);
        @(posedge clk); #1;
        step(1'b1, 1'b0, 4'd1, 8'h99, 1'b1, 2'b00);
        step(1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 2'b00);

        i_v3 = 1'b0; i_vc3 = 2'd2; i_d3 = {1'b1, 4'd1, 8'h42};
        @(negedge clk);
        chk("vc3_legal_o_b", 32'(o_b3), 32'd0);
        chk("vc3_o_err0", 32'(o_err3), 32'd0);
        @(posedge clk); #1;
        i_v3 = 1'b1; i_vc3 = 2'd3;
        @(negedge clk);
        chk("illegal_vc_o_b", 32'(o_b3), 32'd1);
        @(posedge clk); #1;
        i_v3 = 1'b0;
        @(negedge clk);
        chk("illegal_vc_no_flit", 32'(nif3.credit_vc_target), 32'd0);
        chk("illegal_vc_o_err", 32'(o_err3), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/credit_bp_tx.md
# credit_bp_tx

Client-side injection stage that sits directly upstream of a switch input port. It converts a client's valid/backpressure (DVR) flit stream into the credit-based `noc_if` transmitter protocol. It tracks one credit counter per virtual channel, mirroring the receiver's per-VC FIFO occupancy, and issues a flit only when the target VC holds a credit. The output is registered so it can drive a switch `rx` port or a `noc_pipe` directly.

## Interface
- `N`, `DEFAULT_N`: number of clients; carried for address checks only.
- `A_W`, `DEFAULT_A_W`: address width.
- `D_W`, `DEFAULT_D_W`: data width.
- `VC_W`, `DEFAULT_VC_W`: number of virtual channels (one-hot VC width).
- `VC_FIFO_DEPTH`, `DEFAULT_VC_FIFO_DEPTH`: receiver FIFO depth parameter. Initial credits per VC = `VC_FIFO_DEPTH-1`.
- `clk`, input, 1: clock; all state is on the rising edge.
- `rst`, input, 1: reset, **asynchronous, active-low**.
- `i_v`, input, 1: client flit valid.
- `i_d`, input, `A_W+D_W+1`: flit. `[D_W-1:0]` data, `[A_W+D_W-1:D_W]` addr, `[A_W+D_W]` last.
- `i_vc`, input, `$clog2(VC_W)` (min 1): target VC index.
- `o_b`, output, 1: backpressure to client; flit is not accepted while high.
- `to_rx`, `noc_if.transmitter`: drives `credit_packet.{payload.data, routeinfo.addr, payload.last}` and `credit_vc_target[VC_W-1:0]`; receives `credit_vc_credit_gnt[VC_W-1:0]`.
- `o_err`, output, 1: sticky error flag for credit overflow or an illegal VC index.

## Operation
- Credit counters:
  - `cred[v]` has width `$clog2(VC_FIFO_DEPTH)+1`.
  - Reset value is `VC_FIFO_DEPTH-1`; the counter saturates at that value.
- Backpressure: `o_b = (cred[i_vc] == 0) | (i_vc >= VC_W)`.
  - It is a function of registered counters and `i_vc` only.
  - There is no combinational path from `credit_vc_credit_gnt` to `o_b`.
- Accept: `fire = i_v & ~o_b`.
  - On `fire`, `i_d` is registered into the output packet.
  - `credit_vc_target` is registered as one-hot at bit `i_vc`.
  - `cred[i_vc]` decrements.
- On a cycle without `fire`, the registered `credit_vc_target` is 0. The packet register holds its last value; it is don't-care when target is 0.
- Credit return: each set bit `credit_vc_credit_gnt[v]` increments `cred[v]` by 1. All VCs are updated in parallel.
- Same-VC simultaneous decrement and grant: counter unchanged.
- Overflow: a grant arriving while `cred[v] == VC_FIFO_DEPTH-1` sets `o_err`. The counter stays at maximum.
- Illegal VC: `i_v` with `i_vc >= VC_W` sets `o_err` and is never accepted.
- Packet integrity: all flits of one packet (up to and including `last=1`) carry the same `i_vc`. A mid-packet VC change is flagged by a simulation assertion and not corrected.
- Order: flits leave in acceptance order. There is no reordering across VCs.

## Timing
- Reset (async assert, sync release) sets:
  - `credit_vc_target=0`
  - packet register = 0
  - `cred[*]=VC_FIFO_DEPTH-1`
  - `o_err=0`
  - `o_b` evaluates from the reset counters, so it is 0 for a legal `i_vc`.
- Latency: one cycle, from `fire` at edge k to `credit_vc_target`/packet valid during cycle k+1.
- Throughput: 1 flit/cycle while credits remain.
- Credit-use latency: a grant sampled at edge k makes the credit usable at edge k+1. With `cred[v]==0` and a grant in cycle k, `o_b` falls in cycle k+1.
- Reset mid-operation:
  - In-flight outputs are dropped immediately: `credit_vc_target` goes to 0 asynchronously.
  - Counters return to full.
  - The system resets the receiver together with this block.

## Test plan
- Reset then idle (`VC_W=2`, `VC_FIFO_DEPTH=4`) -> `credit_vc_target=0`, `o_b=0`, `o_err=0`. Internal `cred` = 3,3.
- Send 3 flits on VC0 with no grants -> three targets `2'b01` on consecutive cycles. 4th flit: `o_b=1` held, no output. Then a grant on VC0 -> `o_b` drops the next cycle and the 4th flit issues.
- VC0 exhausted; VC1 traffic (`i_vc=1`) -> accepted with `o_b=0`, target `2'b10`. VC isolation holds.
- Accept on VC1 in the same cycle as a grant on VC1 with `cred[1]=1` -> `cred[1]` stays 1 and there is no backpressure.
- Grant on VC0 with `cred[0]=3` -> `o_err=1` sticky until reset, `cred[0]` stays 3.
- Packet `{addr=5, data=0xA5, last=0}`, `{addr=5, data=0x5A, last=1}` on VC1 -> `to_rx` fields match bit-exactly one cycle after accept. Assert `rst` low mid-stream -> target drops to 0 and credits restore to 3.
